// File: rtl/lcd_writer.sv
// HD44780 write sequencer: SETUP / PULSE / HOLD / GAP timing with a one-entry pending slot.
// Define LCD_OVF_FLAG_EN to add the sticky ovf_o dropped-request flag.
module lcd_writer #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 12,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned GAP_CYC   = 40
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lcd_wr_i,
  input  logic [31:0] lcd_word_i,
  output logic        busy_o,
  output logic        lcd_on_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic [7:0]  lcd_data_o
`ifdef LCD_OVF_FLAG_EN
  ,output logic       ovf_o
`endif
);

  localparam int unsigned MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MAX_HG  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int unsigned MAX_CYC = (MAX_SP > MAX_HG) ? MAX_SP : MAX_HG;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned WORD_W  = 10;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_GAP
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [WORD_W-1:0]   r_act, w_act_nxt;
  logic [WORD_W-1:0]   r_pend, w_pend_nxt;
  logic                r_pend_v, w_pend_v_nxt;
  logic                r_en, r_busy;
  logic                w_done, w_last_gap;
  logic [WORD_W-1:0]   w_word;
  logic                w_unused_bits;
`ifdef LCD_OVF_FLAG_EN
  logic                r_ovf, w_drop;
`endif

  // Compact word: {ON, RS, DATA}; remaining CPU bits are ignored.
  assign w_word        = {lcd_word_i[31], lcd_word_i[9], lcd_word_i[7:0]};
  assign w_unused_bits = &{1'b0, lcd_word_i[30:10], lcd_word_i[8]};
  assign w_done        = (r_cnt == '0);
  assign w_last_gap    = (r_state == S_GAP) && w_done;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = w_done ? '0 : r_cnt - CNT_W'(1);
    w_act_nxt    = r_act;
    w_pend_nxt   = r_pend;
    w_pend_v_nxt = r_pend_v;
`ifdef LCD_OVF_FLAG_EN
    w_drop       = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (lcd_wr_i) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = CNT_W'(SETUP_CYC - 1);
          w_act_nxt   = w_word;
        end
      end
      S_SETUP: begin
        if (w_done) begin
          w_state_nxt = S_PULSE;
          w_cnt_nxt   = CNT_W'(PULSE_CYC - 1);
        end
      end
      S_PULSE: begin
        if (w_done) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = CNT_W'(HOLD_CYC - 1);
        end
      end
      S_HOLD: begin
        if (w_done) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = CNT_W'(GAP_CYC - 1);
        end
      end
      S_GAP: begin
        // Last GAP cycle: slot promotes to active and a same-cycle strobe refills it.
        if (w_done) begin
          if (r_pend_v) begin
            w_state_nxt  = S_SETUP;
            w_cnt_nxt    = CNT_W'(SETUP_CYC - 1);
            w_act_nxt    = r_pend;
            w_pend_v_nxt = lcd_wr_i;
            if (lcd_wr_i) w_pend_nxt = w_word;
          end else if (lcd_wr_i) begin
            w_state_nxt = S_SETUP;
            w_cnt_nxt   = CNT_W'(SETUP_CYC - 1);
            w_act_nxt   = w_word;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    // Strobes during a transfer fill the slot, or are dropped when it is full.
    if (lcd_wr_i && (r_state != S_IDLE) && !w_last_gap) begin
      if (!r_pend_v) begin
        w_pend_v_nxt = 1'b1;
        w_pend_nxt   = w_word;
      end else begin
`ifdef LCD_OVF_FLAG_EN
        w_drop = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_act    <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_en     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_act    <= w_act_nxt;
      r_pend   <= w_pend_nxt;
      r_pend_v <= w_pend_v_nxt;
      r_en     <= (w_state_nxt == S_PULSE);
      r_busy   <= (w_state_nxt != S_IDLE) | w_pend_v_nxt;
    end
  end

`ifdef LCD_OVF_FLAG_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ovf <= 1'b0;
    else         r_ovf <= r_ovf | w_drop;
  end
  assign ovf_o = r_ovf;
`endif

  assign busy_o     = r_busy;
  assign lcd_on_o   = r_act[9];
  assign lcd_rs_o   = r_act[8];
  assign lcd_data_o = r_act[7:0];
  assign lcd_en_o   = r_en;
  assign lcd_rw_o   = 1'b0;

endmodule

// File: tb/tb_lcd_writer.sv
// Directed bench for lcd_writer: default timing instance (a) and all-1 timing instance (b).
module tb_lcd_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_a, wr_b;
  logic [31:0] word_a, word_b;
  logic        busy_a, on_a, rs_a, rw_a, en_a;
  logic        busy_b, on_b, rs_b, rw_b, en_b;
  logic [7:0]  data_a, data_b;
`ifdef LCD_OVF_FLAG_EN
  logic        ovf_a, ovf_b;
`endif

  int checks = 0;
  int errors = 0;

  int          st[3];
  logic [31:0] sw[3];
  int          xs[3];
  logic [31:0] xw[3];
  int          ovf_from;

  always #5 clk = ~clk;

  lcd_writer u_a (
    .clk_i(clk), .rst_ni(rst_n), .lcd_wr_i(wr_a), .lcd_word_i(word_a),
    .busy_o(busy_a), .lcd_on_o(on_a), .lcd_rs_o(rs_a), .lcd_rw_o(rw_a),
    .lcd_en_o(en_a), .lcd_data_o(data_a)
`ifdef LCD_OVF_FLAG_EN
    , .ovf_o(ovf_a)
`endif
  );

  lcd_writer #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1), .GAP_CYC(1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .lcd_wr_i(wr_b), .lcd_word_i(word_b),
    .busy_o(busy_b), .lcd_on_o(on_b), .lcd_rs_o(rs_b), .lcd_rw_o(rw_b),
    .lcd_en_o(en_b), .lcd_data_o(data_b)
`ifdef LCD_OVF_FLAG_EN
    , .ovf_o(ovf_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    wr_a   = 1'b0;
    wr_b   = 1'b0;
    word_a = '0;
    word_b = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drive strobes st/sw at offsets from the first edge; check against transfers starting at xs.
  task automatic run(input bit sel, input int n, input int nstr, input int nx);
    int          s_c, p_c, occ;
    logic        wr, exp_en;
    logic [31:0] w;
    s_c = sel ? 1 : 2;
    p_c = sel ? 1 : 12;
    occ = sel ? 4 : 56;
    for (int i = 0; i < n; i++) begin
      wr = 1'b0;
      w  = '0;
      for (int j = 0; j < nstr; j++) if (st[j] == i) begin wr = 1'b1; w = sw[j]; end
      if (sel) begin wr_b = wr; word_b = w; end
      else     begin wr_a = wr; word_a = w; end
      tick();
      wr_a = 1'b0;
      wr_b = 1'b0;
      exp_en = 1'b0;
      for (int x = 0; x < nx; x++)
        if (i >= xs[x] + s_c && i < xs[x] + s_c + p_c) exp_en = 1'b1;
      check($sformatf("en%0d@%0d", sel, i), 32'(sel ? en_b : en_a), 32'(exp_en));
      check($sformatf("busy%0d@%0d", sel, i), 32'(sel ? busy_b : busy_a),
            32'(i < xs[nx-1] + occ));
      check($sformatf("rw%0d@%0d", sel, i), 32'(sel ? rw_b : rw_a), 32'(0));
`ifdef LCD_OVF_FLAG_EN
      check($sformatf("ovf%0d@%0d", sel, i), 32'(sel ? ovf_b : ovf_a),
            32'(ovf_from >= 0 && i >= ovf_from));
`endif
      for (int x = 0; x < nx; x++) begin
        if (i == xs[x] + s_c) begin
          check($sformatf("data%0d_x%0d", sel, x), 32'(sel ? data_b : data_a), 32'(xw[x][7:0]));
          check($sformatf("rs%0d_x%0d", sel, x), 32'(sel ? rs_b : rs_a), 32'(xw[x][9]));
          check($sformatf("on%0d_x%0d", sel, x), 32'(sel ? on_b : on_a), 32'(xw[x][31]));
        end
      end
    end
  endtask

  initial begin
    ovf_from = -1;
    do_reset();
    check("rst_en_a", 32'(en_a), 32'(0));
    check("rst_busy_a", 32'(busy_a), 32'(0));
    check("rst_data_a", 32'(data_a), 32'(0));
    check("rst_on_a", 32'(on_a), 32'(0));
    check("rst_rs_a", 32'(rs_a), 32'(0));
    check("rst_en_b", 32'(en_b), 32'(0));
    check("rst_busy_b", 32'(busy_b), 32'(0));
`ifdef LCD_OVF_FLAG_EN
    check("rst_ovf_a", 32'(ovf_a), 32'(0));
`endif

    // Single write; ON retained after return to IDLE.
    st = '{0, 0, 0}; sw = '{32'h8000_0241, 32'h0, 32'h0};
    xs = '{0, 0, 0}; xw = '{32'h8000_0241, 32'h0, 32'h0};
    run(1'b0, 60, 1, 1);
    check("t1_on_kept", 32'(on_a), 32'(1));
    check("t1_data_kept", 32'(data_a), 32'h41);

    // Second write 5 cycles later waits in the slot.
    do_reset();
    st = '{0, 5, 0}; sw = '{32'h0000_0038, 32'h0000_0201, 32'h0};
    xs = '{0, 56, 0}; xw = '{32'h0000_0038, 32'h0000_0201, 32'h0};
    run(1'b0, 116, 2, 2);

    // Three consecutive strobes: third dropped.
    do_reset();
    ovf_from = 2;
    st = '{0, 1, 2}; sw = '{32'h8000_0011, 32'h0000_0222, 32'h8000_0033};
    xs = '{0, 56, 0}; xw = '{32'h8000_0011, 32'h0000_0222, 32'h0};
    run(1'b0, 116, 3, 2);
    check("t3_data_last", 32'(data_a), 32'h22);

    // Slot full with a strobe on the last GAP cycle: nothing dropped.
    do_reset();
    ovf_from = -1;
    st = '{0, 1, 56}; sw = '{32'h8000_0011, 32'h0000_0222, 32'h8000_0033};
    xs = '{0, 56, 112}; xw = '{32'h8000_0011, 32'h0000_0222, 32'h8000_0033};
    run(1'b0, 172, 3, 3);

    // Reset during PULSE drops EN and busy without a clock edge.
    do_reset();
    wr_a = 1'b1; word_a = 32'h8000_0041;
    tick();
    wr_a = 1'b0;
    repeat (5) tick();
    check("t5_en_before", 32'(en_a), 32'(1));
    rst_n = 1'b0;
    #1;
    check("t5_en_rst", 32'(en_a), 32'(0));
    check("t5_busy_rst", 32'(busy_a), 32'(0));
    check("t5_data_rst", 32'(data_a), 32'(0));
    check("t5_on_rst", 32'(on_a), 32'(0));
    #2 rst_n = 1'b1;
    st = '{0, 0, 0}; sw = '{32'h8000_0041, 32'h0, 32'h0};
    xs = '{0, 0, 0}; xw = '{32'h8000_0041, 32'h0, 32'h0};
    run(1'b0, 60, 1, 1);

    // Minimum timing: 4-cycle occupancy, slot and last-GAP refill.
    do_reset();
    st = '{0, 1, 4}; sw = '{32'h8000_0255, 32'h0000_0102, 32'h8000_0033};
    xs = '{0, 4, 8}; xw = '{32'h8000_0255, 32'h0000_0102, 32'h8000_0033};
    run(1'b1, 16, 3, 3);
    check("t6_on_kept", 32'(on_b), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
